hazard_control_unit: RTL

- Pipeline hazard and stall controller for the RV32IM 5-stage core (IF, ID, EX, MEM, WB).
- Sits alongside the ID/EX boundary, directly upstream of the forwarding unit. It decides when the pipeline must stall, bubble or flush, because forwarding cannot resolve three cases: load-use dependencies, multi-cycle M-extension operations and data-memory wait states.
- It drives the enable and clear controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/hazard_control_unit_if.sv | 56 +++++
 rtl/hazard_control_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/hazard_control_unit_if.sv
// Port bundle for hazard_control_unit: hazard-detection inputs from ID/EX/MEM and stage controls out.
// Define HAZARD_PERF_EN to add the performance-counter clear input and counter outputs.
interface hazard_control_unit_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] id_addr1;
  logic [ADDR_W-1:0] id_addr2;
  logic              id_use1;
  logic              id_use2;
  logic [ADDR_W-1:0] exe_addr;
  logic              exe_memread;
  logic              exe_muldiv_start;
  logic              muldiv_done;
  logic              mem_busy;
  logic              branch_taken;

  logic pc_stall;
  logic ifid_stall;
  logic ifid_flush;
  logic idex_stall;
  logic idex_bubble;
  logic exmem_stall;
  logic exmem_bubble;
  logic memwb_bubble;
  logic mem_err;

`ifdef HAZARD_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_lu_cnt;
  logic [31:0] perf_muldiv_cnt;
  logic [31:0] perf_mem_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  modport master (
`ifdef HAZARD_PERF_EN
    output perf_clr,
    input  perf_lu_cnt, perf_muldiv_cnt, perf_mem_cnt, perf_flush_cnt,
`endif
    output id_addr1, id_addr2, id_use1, id_use2, exe_addr, exe_memread,
           exe_muldiv_start, muldiv_done, mem_busy, branch_taken,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           exmem_stall, exmem_bubble, memwb_bubble, mem_err
  );

  modport slave (
`ifdef HAZARD_PERF_EN
    input  perf_clr,
    output perf_lu_cnt, perf_muldiv_cnt, perf_mem_cnt, perf_flush_cnt,
`endif
    input  id_addr1, id_addr2, id_use1, id_use2, exe_addr, exe_memread,
           exe_muldiv_start, muldiv_done, mem_busy, branch_taken,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           exmem_stall, exmem_bubble, memwb_bubble, mem_err
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall / bubble / flush controller for the 5-stage RV32IM pipeline (load-use, mul/div, memory wait).
// Define HAZARD_PERF_EN to add per-cause 32-bit performance counters with synchronous clear.
module hazard_control_unit #(
  parameter int ADDR_W      = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  reset_n,
  hazard_control_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, MULDIV_WAIT, MEM_WAIT} state_t;

  localparam logic [7:0]        TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [ADDR_W-1:0] REG_X0  = '0;

  state_t     state;
  logic [7:0] timeout_cnt;
  logic       mem_err_q;
  logic       load_use;
  logic       freeze;
  logic       md_stall;
  logic       br_flush;
  logic       lu_stall;

  // Exactly one cause is active per cycle; everything is forced idle while reset is held.
  always_comb begin
    load_use = bus.exe_memread && (bus.exe_addr != REG_X0) &&
               ((bus.id_use1 && (bus.id_addr1 == bus.exe_addr)) ||
                (bus.id_use2 && (bus.id_addr2 == bus.exe_addr)));
    freeze   = reset_n && bus.mem_busy;
    md_stall = 1'b0;
    br_flush = 1'b0;
    lu_stall = 1'b0;
    if (reset_n && !bus.mem_busy) begin
      case (state)
        RUN: begin
          if (bus.exe_muldiv_start)  md_stall = !bus.muldiv_done;
          else if (bus.branch_taken) br_flush = 1'b1;
          else if (load_use)         lu_stall = 1'b1;
        end
        MULDIV_WAIT: md_stall = !bus.muldiv_done;
        default: ;
      endcase
    end
  end

  assign bus.pc_stall     = freeze | md_stall | lu_stall;
  assign bus.ifid_stall   = freeze | md_stall | lu_stall;
  assign bus.ifid_flush   = br_flush;
  assign bus.idex_stall   = freeze | md_stall;
  assign bus.idex_bubble  = br_flush | lu_stall;
  assign bus.exmem_stall  = freeze;
  assign bus.exmem_bubble = md_stall;
  assign bus.memwb_bubble = freeze;
  assign bus.mem_err      = mem_err_q;

  // The timeout counter holds the number of busy cycles already frozen in the current episode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      timeout_cnt <= 8'd0;
      mem_err_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.mem_busy) begin
            state       <= MEM_WAIT;
            timeout_cnt <= 8'd1;
            if (TIMEOUT <= 8'd1) mem_err_q <= 1'b1;
          end else if (bus.exe_muldiv_start && !bus.muldiv_done) begin
            state <= MULDIV_WAIT;
          end
        end
        MULDIV_WAIT: begin
          if (!bus.mem_busy && bus.muldiv_done) state <= RUN;
        end
        MEM_WAIT: begin
          if (bus.mem_busy) begin
            if (timeout_cnt < TIMEOUT)          timeout_cnt <= timeout_cnt + 8'd1;
            if (timeout_cnt >= TIMEOUT - 8'd1) mem_err_q   <= 1'b1;
          end else begin
            state       <= RUN;
            timeout_cnt <= 8'd0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt;
  logic [31:0] md_cnt;
  logic [31:0] mem_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_cnt    <= 32'd0;
      md_cnt    <= 32'd0;
      mem_cnt   <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (bus.perf_clr) begin
      lu_cnt    <= 32'd0;
      md_cnt    <= 32'd0;
      mem_cnt   <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (lu_stall) lu_cnt    <= lu_cnt + 32'd1;
      if (md_stall) md_cnt    <= md_cnt + 32'd1;
      if (freeze)   mem_cnt   <= mem_cnt + 32'd1;
      if (br_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.perf_lu_cnt     = lu_cnt;
  assign bus.perf_muldiv_cnt = md_cnt;
  assign bus.perf_mem_cnt    = mem_cnt;
  assign bus.perf_flush_cnt  = flush_cnt;
`endif
endmodule
